// File: rtl/write_buffer.sv
// write_buffer: word-granular store buffer draining to the data bus in order.
// Define WB_FWD_EN to forward loads from the youngest matching buffered store.
module write_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cache_rd,
    input  logic                  cache_wr,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic [DATA_WIDTH-1:0] cache_data,
    output logic                  cache_waitrequest,
    output logic                  bus_rd,
    output logic                  bus_wr,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    input  logic [DATA_WIDTH-1:0] bus_rd_data,
    input  logic                  bus_waitrequest,
    output logic                  wb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {B_IDLE, B_WRITE, B_READ} bus_state_t;
    bus_state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      head, tail;
    logic [CNT_W-1:0]      count;

    logic                  full, push, pop, rd_done, load_eligible, fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    // A full buffer refuses the store even if the head pops this cycle.
    assign full     = (count == CNT_W'(DEPTH));
    assign push     = cache_wr && !cache_rd && !full;
    assign pop      = (state == B_WRITE) && !bus_waitrequest;
    assign rd_done  = (state == B_READ) && !bus_waitrequest;
    assign wb_empty = (count == '0) && (state == B_IDLE);

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that skips assignment would infer a latch.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_mem[fwd_idx] == cache_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[fwd_idx];
            end
        end
    end

    assign load_eligible = !fwd_hit;
`else
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
    assign load_eligible = (count == '0);
`endif

    always_comb begin
        cache_data        = '0;
        cache_waitrequest = 1'b0;
        if (cache_rd) begin
            if (fwd_hit) begin
                cache_data = fwd_data;
            end else if (rd_done) begin
                cache_data = bus_rd_data;
            end else begin
                cache_waitrequest = 1'b1;
            end
        end else if (cache_wr) begin
            cache_waitrequest = full;
        end
    end

    // Loads take priority over draining so a bypassing read is not stuck behind stores.
    always_comb begin
        state_next = state;
        unique case (state)
            B_IDLE: begin
                if (cache_rd && !fwd_hit && load_eligible) begin
                    state_next = B_READ;
                end else if (count != '0) begin
                    state_next = B_WRITE;
                end
            end
            B_WRITE: if (!bus_waitrequest) state_next = B_IDLE;
            B_READ:  if (!bus_waitrequest) state_next = B_IDLE;
            default: state_next = B_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= B_IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            bus_rd      <= 1'b0;
            bus_wr      <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
        end else begin
            state <= state_next;
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            if (state == B_IDLE && state_next == B_READ) begin
                bus_rd   <= 1'b1;
                bus_addr <= cache_addr;
            end else if (state == B_IDLE && state_next == B_WRITE) begin
                bus_wr      <= 1'b1;
                bus_addr    <= addr_mem[head];
                bus_wr_data <= data_mem[head];
            end
            if (rd_done) bus_rd <= 1'b0;
            if (pop)     bus_wr <= 1'b0;
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every read, so stale words are never observed.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[tail] <= cache_addr;
            data_mem[tail] <= cache_wr_data;
        end
    end
endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: directed scenarios plus randomized traffic against a memory model.
// Honours WB_FWD_EN the same way as the design.
module tb_write_buffer;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 200;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cache_rd = 1'b0, cache_wr = 1'b0;
    logic [AW-1:0] cache_addr = '0;
    logic [DW-1:0] cache_wr_data = '0;
    logic [DW-1:0] cache_data;
    logic          cache_waitrequest;
    logic          bus_rd, bus_wr;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data = '0;
    logic          bus_waitrequest = 1'b0;
    logic          wb_empty;

    write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .cache_rd(cache_rd), .cache_wr(cache_wr), .cache_addr(cache_addr),
        .cache_wr_data(cache_wr_data), .cache_data(cache_data),
        .cache_waitrequest(cache_waitrequest),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_waitrequest(bus_waitrequest), .wb_empty(wb_empty)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0, cyc = 0;
    logic [DW-1:0]    model_mem [logic [AW-1:0]];   // program-order view of memory
    logic [DW-1:0]    bus_mem   [logic [AW-1:0]];   // what the bus has actually seen
    logic [AW+DW-1:0] exp_wr_q  [$];
    logic [DW-1:0]    exp_load_q [$];
    logic [AW:0]      cmd_log   [$];                // {is_read, addr} per completed bus command
    int wr_done = 0, rd_done = 0, last_wr_cyc = -1, bus_rd_cycles = 0, bus_wr_cycles = 0;
    int bus_mode = 0;      // 0 free, 1 always stalled, 2 random stall
    int stall_left = 0;

    always @(posedge clock) cyc++;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: got %s (cycle %0d)", name, what, cyc);
    endtask

    // Bus slave: read data is only meaningful on the completing cycle, garbage otherwise.
    always @(posedge clock) begin
        #1;
        if (bus_mode == 1) begin
            bus_waitrequest = 1'b1;
        end else if (stall_left > 0 && (bus_rd || bus_wr)) begin
            bus_waitrequest = 1'b1;
            stall_left--;
        end else if (bus_mode == 2) begin
            bus_waitrequest = ($urandom_range(0, 1) == 1);
        end else begin
            bus_waitrequest = 1'b0;
        end
        bus_rd_data = (bus_rd && !bus_waitrequest) ? mem_read(bus_addr) : $urandom;
    end

    int mon_pend;
    logic [AW+DW-1:0] mon_exp;

    always @(negedge clock) begin
        if (!reset) begin
            mon_pend = (cache_wr && !cache_rd) ? 1 : 0;
            check("wb_empty", wb_empty, (exp_wr_q.size() - mon_pend == 0) && !bus_rd && !bus_wr);
            check("bus_exclusive", bus_rd && bus_wr, 0);
            if (cache_rd && !cache_waitrequest) begin
                if (exp_load_q.size() == 0) fail("unexpected_load", "completion with nothing expected");
                else check("load_data", cache_data, exp_load_q.pop_front());
            end else begin
                check("cache_data_zero", cache_data, 0);
            end
            if (!cache_rd && !cache_wr) check("idle_waitrequest", cache_waitrequest, 0);
            if (bus_wr) bus_wr_cycles++;
            if (bus_rd) bus_rd_cycles++;
            if (bus_wr && !bus_waitrequest) begin
                if (exp_wr_q.size() == 0) begin
                    fail("unexpected_write", "bus write with nothing buffered");
                end else begin
                    mon_exp = exp_wr_q.pop_front();
                    check("wr_addr", bus_addr, mon_exp[AW+DW-1:DW]);
                    check("wr_data", bus_wr_data, mon_exp[DW-1:0]);
                end
                bus_mem[bus_addr] = bus_wr_data;
                wr_done++;
                last_wr_cyc = cyc;
                cmd_log.push_back({1'b0, bus_addr});
            end
            if (bus_rd && !bus_waitrequest) begin
                check("rd_addr", bus_addr, cache_addr);
`ifndef WB_FWD_EN
                check("rd_after_drain", exp_wr_q.size(), 0);
`endif
                rd_done++;
                cmd_log.push_back({1'b1, bus_addr});
            end
        end
    end

    task automatic idle(input int n);
        cache_rd = 1'b0;
        cache_wr = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input int release_after,
                            output int waited, output int acc_cyc);
        model_mem[a] = d;
        exp_wr_q.push_back({a, d});
        cache_rd = 1'b0; cache_wr = 1'b1; cache_addr = a; cache_wr_data = d;
        waited = 0;
        acc_cyc = -1;
        forever begin
            @(negedge clock);
            if (!cache_waitrequest) begin
                acc_cyc = cyc;
                break;
            end
            waited++;
            if (waited == release_after) bus_mode = 0;
            if (waited >= TIMEOUT) begin
                fail("store_timeout", "store never accepted");
                break;
            end
        end
        @(posedge clock);
        #1;
        cache_wr = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic also_wr, input int release_after,
                           output int waited);
        exp_load_q.push_back(model_mem.exists(a) ? model_mem[a] : init_val(a));
        cache_rd = 1'b1; cache_wr = also_wr; cache_addr = a; cache_wr_data = $urandom;
        waited = 0;
        forever begin
            @(negedge clock);
            if (!cache_waitrequest) break;
            waited++;
            if (waited == release_after) bus_mode = 0;
            if (waited >= TIMEOUT) begin
                fail("load_timeout", "load never completed");
                break;
            end
        end
        @(posedge clock);
        #1;
        cache_rd = 1'b0;
        cache_wr = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        cache_rd = 1'b0;
        cache_wr = 1'b0;
        while (!(wb_empty && exp_wr_q.size() == 0) && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        if (n >= TIMEOUT) fail("drain_timeout", "buffer never drained");
        @(posedge clock);
        #1;
    endtask

    int waited, acc, wr_before, rd_before, rnd;
    logic [AW-1:0] ra;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_bus_rd", bus_rd, 0);
        check("rst_bus_wr", bus_wr, 0);
        check("rst_wb_empty", wb_empty, 1);
        check("rst_waitrequest", cache_waitrequest, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wr_data", bus_wr_data, 0);
        @(posedge clock);
        #1;

        // Fill the buffer against a stalled bus, then a fifth store must wait for the first pop.
        bus_mode = 1;
        wr_before = wr_done;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), -1, waited, acc);
            check("fill_no_wait", waited, 0);
        end
        do_store(32'h110, 32'hA4, 3, waited, acc);
        check("full_stall_cycles", waited, 4);
        check("fifth_after_first_pop", acc, last_wr_cyc + 1);
        check("pops_before_fifth", wr_done - wr_before, 1);
        wait_drain();
        check("fill_drain_count", wr_done - wr_before, 5);

        // Bus load on an empty buffer with two stall cycles.
        bus_mem[32'h200] = 32'hDEAD_BEEF;
        model_mem[32'h200] = 32'hDEAD_BEEF;
        stall_left = 2;
        do_load(32'h200, 1'b0, -1, waited);
        check("bus_load_latency", waited, 3);
        @(negedge clock);
        check("load_data_after", cache_data, 0);
        @(posedge clock);
        #1;

        // Two stores to one address, then a load of it with the bus stalled.
        bus_mode = 1;
        do_store(32'h100, 32'h11, -1, waited, acc);
        do_store(32'h100, 32'h22, -1, waited, acc);
        rd_before = rd_done;
        wr_before = wr_done;
`ifdef WB_FWD_EN
        acc = bus_rd_cycles;
        do_load(32'h100, 1'b0, -1, waited);
        check("fwd_same_cycle", waited, 0);
        check("fwd_no_bus_rd", bus_rd_cycles - acc, 0);
        bus_mode = 0;
        wait_drain();
`else
        do_load(32'h100, 1'b0, 4, waited);
        check("load_after_writes", wr_done - wr_before, 2);
        check("load_one_bus_read", rd_done - rd_before, 1);
        wait_drain();
`endif

        // Load to a different address right behind a buffered store.
        bus_mode = 0;
        cmd_log.delete();
        do_store(32'h100, 32'h55, -1, waited, acc);
        do_load(32'h300, 1'b0, -1, waited);
        wait_drain();
        if (cmd_log.size() < 2) begin
            fail("cmd_order", "fewer than two bus commands");
        end else begin
`ifdef WB_FWD_EN
            check("cmd_order_first", cmd_log[0], {1'b1, 32'h300});
            check("cmd_order_second", cmd_log[1], {1'b0, 32'h100});
`else
            check("cmd_order_first", cmd_log[0], {1'b0, 32'h100});
            check("cmd_order_second", cmd_log[1], {1'b1, 32'h300});
`endif
        end

        // Simultaneous read and write: the load is served, the store dropped.
        wr_before = wr_done;
        do_load(32'h140, 1'b1, -1, waited);
        wait_drain();
        check("illegal_wr_ignored", wr_done - wr_before, 0);

        // Randomized traffic over a small address window so forwarding and full stalls both occur.
        bus_mode = 2;
        for (int n = 0; n < 300; n++) begin
            rnd = $urandom_range(0, 9);
            ra = 32'h100 + 32'(4 * $urandom_range(0, 5));
            if (rnd < 5) do_store(ra, $urandom, -1, waited, acc);
            else if (rnd < 8) do_load(ra, 1'b0, -1, waited);
            else idle(1);
        end
        bus_mode = 0;
        wait_drain();
        check("rand_loads_all_done", exp_load_q.size(), 0);

        // Reset while a write is held on the bus discards everything buffered.
        bus_mode = 1;
        for (int i = 0; i < 3; i++) do_store(32'h400 + 32'(4 * i), $urandom, -1, waited, acc);
        idle(1);
        check("pre_reset_bus_wr", bus_wr, 1);
        reset = 1'b1;
        exp_wr_q.delete();
        for (int i = 0; i < 3; i++) model_mem.delete(32'h400 + 32'(4 * i));
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_bus_wr", bus_wr, 0);
        check("post_reset_wb_empty", wb_empty, 1);
        check("post_reset_bus_addr", bus_addr, 0);
        @(posedge clock);
        #1;
        bus_mode = 0;
        wr_before = wr_done;
        acc = bus_wr_cycles;
        idle(10);
        check("no_writes_after_reset", wr_done - wr_before, 0);
        check("no_bus_wr_after_reset", bus_wr_cycles - acc, 0);
        do_load(32'h400, 1'b0, -1, waited);
        idle(2);
        check("final_loads_done", exp_load_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
